lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 22 ++
 rtl/lsu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - single-beat word bus between the load/store unit and memory
interface lsu_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 bus_req;
  logic                 bus_we;
  logic [CPU_WIDTH-1:0] bus_addr;
  logic [3:0]           bus_wstrb;
  logic [CPU_WIDTH-1:0] bus_wdata;
  logic                 bus_ack;
  logic [CPU_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: sized, lane-aligned accesses over a word bus with timeout
module lsu #(
  parameter int CPU_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_start,
  input  logic                 lsu_we,
  input  logic [2:0]           lsu_size,
  input  logic [CPU_WIDTH-1:0] lsu_addr,
  input  logic [CPU_WIDTH-1:0] lsu_wdata,
  output logic                 lsu_busy,
  output logic                 lsu_done,
  output logic                 lsu_err,
  output logic [CPU_WIDTH-1:0] lsu_rdata,
  lsu_if.master                bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Counter value reached on the last ACCESS cycle before giving up.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           lane_q, lane_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
  logic                 req_q, req_d;
  logic                 bwe_q, bwe_d;
  logic [CPU_WIDTH-1:0] baddr_q, baddr_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [CPU_WIDTH-1:0] bwdata_q, bwdata_d;

  logic                 illegal;
  logic [3:0]           strb_new;
  logic [CPU_WIDTH-1:0] wdata_new;
  logic [CPU_WIDTH-1:0] load_val;
  logic [7:0]           rbyte;
  logic [15:0]          rhalf;

  // Reject unknown sizes, unsigned stores and accesses that straddle their natural alignment.
  always_comb begin
    illegal = 1'b0;
    case (lsu_size)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = lsu_addr[0];
      3'b010:  illegal = |lsu_addr[1:0];
      3'b100:  illegal = lsu_we;
      3'b101:  illegal = lsu_we | lsu_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Position store data on its byte lanes; narrow stores replicate so any lane sees the data.
  always_comb begin
    strb_new  = 4'b0000;
    wdata_new = lsu_wdata;
    if (lsu_we) begin
      case (lsu_size[1:0])
        2'b00: begin
          strb_new  = 4'b0001 << lsu_addr[1:0];
          wdata_new = {(CPU_WIDTH/8){lsu_wdata[7:0]}};
        end
        2'b01: begin
          strb_new  = 4'b0011 << lsu_addr[1:0];
          wdata_new = {(CPU_WIDTH/16){lsu_wdata[15:0]}};
        end
        default: strb_new = 4'b1111;
      endcase
    end
  end

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    rbyte = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    rhalf = bus.bus_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      3'b000:  load_val = {{(CPU_WIDTH-8){rbyte[7]}}, rbyte};
      3'b100:  load_val = {{(CPU_WIDTH-8){1'b0}}, rbyte};
      3'b001:  load_val = {{(CPU_WIDTH-16){rhalf[15]}}, rhalf};
      3'b101:  load_val = {{(CPU_WIDTH-16){1'b0}}, rhalf};
      default: load_val = bus.bus_rdata;
    endcase
  end

  // Next-state and next-output logic; done/err are pulses so they default low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    lane_d   = lane_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    req_d    = req_q;
    bwe_d    = bwe_q;
    baddr_d  = baddr_q;
    wstrb_d  = wstrb_q;
    bwdata_d = bwdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_start) begin
          we_d   = lsu_we;
          size_d = lsu_size;
          lane_d = lsu_addr[1:0];
          busy_d = 1'b1;
          if (illegal) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d  = ACCESS;
            cnt_d    = 8'd0;
            req_d    = 1'b1;
            bwe_d    = lsu_we;
            baddr_d  = {lsu_addr[CPU_WIDTH-1:2], 2'b00};
            wstrb_d  = strb_new;
            bwdata_d = wdata_new;
          end
        end
      end
      ACCESS: begin
        if (bus.bus_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = we_q ? '0 : load_val;
        end else if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register state and every output; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      lane_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      wstrb_q  <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      bwe_q    <= bwe_d;
      baddr_q  <= baddr_d;
      wstrb_q  <= wstrb_d;
      bwdata_q <= bwdata_d;
    end
  end

  assign lsu_busy      = busy_q;
  assign lsu_done      = done_q;
  assign lsu_err       = err_q;
  assign lsu_rdata     = rdata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = bwe_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = bwdata_q;
endmodule
